instr_fetch: RTL and testbench

Instruction fetch stage of the simple processor. It sits directly upstream of `ins_dec`. It owns the program counter and drives the instruction-memory request/acknowledge handshake. Fetched 16-bit instructions and their PCs are held in a 2-entry buffer and presented to the decoder through a valid/ready handshake. A redirect port from the execution block steers the PC on jumps and branches.

---
 rtl/simple_processor_pkg.sv | 26 ++
 rtl/fetch_buf.sv | 52 +++++
 rtl/instr_fetch.sv | 140 ++++++++++++++
 tb/tb_instr_fetch.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_processor_pkg.sv
// Shared types and widths for the simple processor pipeline.
package simple_processor_pkg;

  localparam int ADDR_WIDTH  = 16;
  localparam int DATA_WIDTH  = 32;
  localparam int INSTR_WIDTH = 16;

  // Fetch stage control states.
  typedef enum logic [1:0] {
    RESET,
    FETCH,
    DRAIN
  } fetch_state_t;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Instructions are 16-bit aligned, so bit 0 of any fetch address is zero.
  function automatic logic [ADDR_WIDTH-1:0] even_addr(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding fetched instructions for the decoder.
// Flush wins over push and pop issued in the same cycle.
module fetch_buf
  import simple_processor_pkg::*;
(
  input  logic         clk_i,
  input  logic         arst_ni,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;

  // Storage and pointers; the entries are cleared on reset so the head reads zero.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      // NOTE: the storage is reset as well because the head drives outputs whose reset value is defined.
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, runs the instruction-memory
// request/ack handshake and feeds the decoder from a 2-entry buffer.
// The buffer entry type follows the package widths, so ADDR_WIDTH is
// expected to stay at its package default.
module instr_fetch #(
  parameter int ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH
) (
  input  logic                                   clk_i,
  input  logic                                   arst_ni,
  input  logic [ADDR_WIDTH-1:0]                  boot_addr_i,
  output logic                                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]                  imem_addr_o,
  input  logic [DATA_WIDTH-1:0]                  imem_rdata_i,
  input  logic                                   imem_ack_i,
  input  logic                                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]                  redirect_addr_i,
  output logic                                   instr_valid_o,
  output logic [simple_processor_pkg::INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]                  instr_pc_o,
  input  logic                                   instr_ready_i
);

  import simple_processor_pkg::*;

  fetch_state_t          state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  req_q;   // doubles as the outstanding-request flag

  logic                  acked;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  can_issue;
  logic [1:0]            count;
  logic [1:0]            count_next;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  buf_valid;
  fetch_entry_t          push_entry;
  fetch_entry_t          head;

  // Only the low INSTR_WIDTH bits of the read data carry the instruction.
  generate
    if (DATA_WIDTH > INSTR_WIDTH) begin : g_unused_rdata
      logic unused_rdata;
      assign unused_rdata = ^imem_rdata_i[DATA_WIDTH-1:INSTR_WIDTH];
    end
  endgenerate

  // An ack only counts while our request is actually raised.
  assign acked           = req_q && imem_ack_i;
  assign push            = (state_q == FETCH) && acked && !redirect_i;
  assign pop             = buf_valid && instr_ready_i && !redirect_i;
  assign flush           = redirect_i;
  assign count_next      = flush ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
  assign can_issue       = (count_next < 2'd2);
  assign pc_inc          = pc_q + ADDR_WIDTH'(2);
  assign redirect_target = even_addr(redirect_addr_i);

  assign push_entry.pc    = addr_q;
  assign push_entry.instr = imem_rdata_i[INSTR_WIDTH-1:0];

  fetch_buf u_fetch_buf (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (flush),
    .head_o  (head),
    .valid_o (buf_valid),
    .count_o (count)
  );

  // Fetch control: PC, state and the held request. The next request is
  // decided a cycle ahead so req/addr leave the block straight from flops.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      // NOTE: state uses non-blocking assignments so every branch sees the pre-edge values.
      state_q <= RESET;
      pc_q    <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        RESET: begin
          state_q <= FETCH;
          pc_q    <= even_addr(boot_addr_i);
          addr_q  <= even_addr(boot_addr_i);
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (redirect_i) begin
            pc_q <= redirect_target;
            if (req_q && !imem_ack_i) begin
              // The pending request must still complete; its data will be dropped.
              state_q <= DRAIN;
            end else begin
              req_q  <= 1'b1;
              addr_q <= redirect_target;
            end
          end else if (req_q && !imem_ack_i) begin
            // Hold request and address until the memory acknowledges.
          end else begin
            if (acked) begin
              pc_q <= pc_inc;
            end
            req_q <= can_issue;
            if (can_issue) begin
              addr_q <= acked ? pc_inc : pc_q;
            end
          end
        end
        DRAIN: begin
          if (redirect_i) begin
            pc_q <= redirect_target;
          end
          if (imem_ack_i) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
            addr_q  <= redirect_i ? redirect_target : pc_q;
          end
        end
        default: begin
          state_q <= RESET;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = buf_valid;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch with a transaction-level reference model
// and a scoreboard of instructions the decoder should receive, in order.
module tb_instr_fetch;
  import simple_processor_pkg::*;

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int IW = INSTR_WIDTH;

  logic          clk_i = 1'b0;
  logic          arst_ni = 1'b0;
  logic [AW-1:0] boot_addr_i = '0;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic [DW-1:0] imem_rdata_i = '0;
  logic          imem_ack_i = 1'b0;
  logic          redirect_i = 1'b0;
  logic [AW-1:0] redirect_addr_i = '0;
  logic          instr_valid_o;
  logic [IW-1:0] instr_o;
  logic [AW-1:0] instr_pc_o;
  logic          instr_ready_i = 1'b0;

  instr_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i           (clk_i),
    .arst_ni         (arst_ni),
    .boot_addr_i     (boot_addr_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_rdata_i    (imem_rdata_i),
    .imem_ack_i      (imem_ack_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_ready_i   (instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the decoder should see, and where the fetcher should be.
  fetch_entry_t  sb[$];          // instructions currently held in the buffer
  fetch_entry_t  pend;           // accepted this cycle, visible next cycle
  bit            pend_v = 0;
  bit            flush_v = 0;    // redirect this cycle, buffer empty next cycle
  bit            draining = 0;   // outstanding request whose data is to be dropped
  bit            m_out = 0;      // a request is held over from the previous cycle
  logic [AW-1:0] m_addr = '0;    // address of that held request
  logic [AW-1:0] m_pc = '0;      // next sequential fetch address
  int            wait_left = 0;
  bit            mon_en = 0;

  // Stimulus knobs.
  int            lat_min = 0, lat_max = 0, ready_pct = 100, redir_pct = 0;
  bit            spur_ack = 0;
  bit            force_redir = 0;
  logic [AW-1:0] force_tgt = '0;

  // Monitor: checks the decoder-facing side against the scoreboard mid-cycle.
  always @(negedge clk_i) begin
    if (mon_en) begin
      check("instr_valid", 32'(instr_valid_o), 32'(sb.size() > 0));
      if (instr_valid_o && sb.size() > 0) begin
        check("instr_pc", 32'(instr_pc_o), 32'(sb[0].pc));
        check("instr", 32'(instr_o), 32'(sb[0].instr));
        if (instr_ready_i && !redirect_i) void'(sb.pop_front());
      end
    end
  end

  // One clock cycle: commit last cycle's effects, check the request, drive inputs, update the model.
  task automatic step();
    logic          exp_req;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] tgt;
    logic [DW-1:0] rd;
    bit            ack_v, redir, rdy;
    @(posedge clk_i); #1;
    if (flush_v) sb.delete();
    if (pend_v) sb.push_back(pend);
    flush_v = 0;
    pend_v  = 0;

    exp_req  = 1'b0;
    exp_addr = m_pc;
    if (draining || m_out) begin
      exp_req  = 1'b1;
      exp_addr = m_addr;
    end else if (sb.size() < 2) begin
      exp_req = 1'b1;
    end
    check("imem_req", 32'(imem_req_o), 32'(exp_req));
    if (exp_req) check("imem_addr", 32'(imem_addr_o), 32'(exp_addr));

    if (exp_req && !draining && !m_out) wait_left = $urandom_range(lat_max, lat_min);
    ack_v = exp_req && (wait_left == 0);
    if (exp_req && !ack_v) wait_left--;

    rd    = DW'($urandom);
    rdy   = ($urandom_range(99, 0) < ready_pct);
    redir = force_redir || ($urandom_range(99, 0) < redir_pct);
    tgt   = force_redir ? force_tgt : AW'($urandom);
    force_redir = 0;

    imem_ack_i      = ack_v || (spur_ack && !exp_req && $urandom_range(3, 0) == 0);
    imem_rdata_i    = rd;
    instr_ready_i   = rdy;
    redirect_i      = redir;
    redirect_addr_i = tgt;

    if (draining) begin
      if (redir) begin
        flush_v = 1;
        m_pc    = {tgt[AW-1:1], 1'b0};
      end
      if (ack_v) begin
        draining = 0;
        m_out    = 0;
      end
    end else if (redir) begin
      flush_v = 1;
      m_pc    = {tgt[AW-1:1], 1'b0};
      if (exp_req && !ack_v) begin
        draining = 1;
        m_addr   = exp_addr;
      end
      m_out = 0;
    end else if (exp_req && ack_v) begin
      pend.pc    = exp_addr;
      pend.instr = rd[IW-1:0];
      pend_v     = 1;
      m_pc       = exp_addr + AW'(2);
      m_out      = 0;
    end else if (exp_req) begin
      m_out  = 1;
      m_addr = exp_addr;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req_o),    32'd0);
    check({tag, "_addr"},  32'(imem_addr_o),   32'd0);
    check({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
    check({tag, "_instr"}, 32'(instr_o),       32'd0);
    check({tag, "_pc"},    32'(instr_pc_o),    32'd0);
  endtask

  task automatic do_reset(input logic [AW-1:0] boot);
    mon_en          = 0;
    arst_ni         = 1'b0;
    imem_ack_i      = 1'b0;
    redirect_i      = 1'b0;
    instr_ready_i   = 1'b0;
    boot_addr_i     = boot;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    @(negedge clk_i);
    arst_ni = 1'b1;
    #1;
    check("first_cycle_req", 32'(imem_req_o), 32'd0);
    sb.delete();
    pend_v    = 0;
    flush_v   = 0;
    draining  = 0;
    m_out     = 0;
    m_pc      = {boot[AW-1:1], 1'b0};
    wait_left = 0;
    mon_en    = 1;
  endtask

  task automatic knobs(input int lmin, input int lmax, input int rp, input int dp, input bit sp);
    lat_min   = lmin;
    lat_max   = lmax;
    ready_pct = rp;
    redir_pct = dp;
    spur_ack  = sp;
  endtask

  initial begin
    // Boot at 0x0100 with zero-wait memory and an always-ready decoder.
    do_reset(AW'(16'h0100));
    knobs(0, 0, 100, 0, 0);
    repeat (20) step();

    // Three wait states per access.
    knobs(3, 3, 100, 0, 0);
    repeat (20) step();

    // Back-pressure, then release.
    knobs(0, 0, 0, 0, 0);
    repeat (8) step();
    knobs(0, 0, 100, 0, 0);
    repeat (10) step();

    // Redirect to 0x0201 while a slow request is outstanding.
    knobs(3, 3, 100, 0, 0);
    for (int i = 0; i < 10 && !m_out; i++) step();
    check("setup_outstanding", 32'(m_out), 32'd1);
    force_redir = 1;
    force_tgt   = AW'(16'h0201);
    step();
    repeat (12) step();

    // Redirect, ack and pop all in the same cycle.
    knobs(0, 0, 100, 0, 0);
    repeat (4) step();
    force_redir = 1;
    force_tgt   = AW'(16'h0300);
    step();
    repeat (6) step();

    // Randomized traffic with spurious acks and redirects.
    knobs(0, 3, 70, 5, 1);
    repeat (600) step();
    knobs(0, 1, 40, 10, 1);
    repeat (300) step();

    // Wrap-around from the top of the address space.
    do_reset({{(AW-1){1'b1}}, 1'b0});
    knobs(0, 0, 100, 0, 0);
    step();
    step();
    check("wrap_next_addr", 32'(imem_addr_o), 32'd0);
    repeat (3) step();

    // Asynchronous reset in the middle of a request.
    knobs(3, 3, 100, 0, 0);
    step();
    step();
    #2;
    mon_en  = 0;
    arst_ni = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    do_reset(AW'(16'h0040));
    knobs(0, 2, 80, 3, 1);
    repeat (100) step();

    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
